dot_product_sequencer: RTL and testbench

Sequences a single `fuseMultAdd` unit to compute a seeded dot product, seed + Σ A[i]·B[i].
- Accepts a command (two operand base addresses, element count, seed).
- Streams operand pairs out of a dual-read operand memory and drives the FMA control pins.
- Returns the accumulator value through a valid/ready result port.
- Sits in the matrix processor between the tile scheduler (command/result side) and one FMA lane plus its operand RAM.

---
 rtl/matrix_pkg.sv | 4 +
 rtl/dot_product_sequencer_if.sv | 25 ++
 rtl/operand_addr_gen.sv | 42 ++++
 rtl/dot_product_sequencer.sv | 83 ++++++++
 tb/tb_dot_product_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared types for the matrix processor sequencing blocks.
package matrix_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;
endpackage

// File: rtl/dot_product_sequencer_if.sv
// Command/result handshake between the tile scheduler and a dot-product sequencer.
interface dot_product_sequencer_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base_a;
  logic [ADDR_W-1:0] cmd_base_b;
  logic [LEN_W-1:0]  cmd_len;
  logic [WIDTH-1:0]  cmd_seed;
  logic              res_valid;
  logic              res_ready;
  logic [WIDTH-1:0]  res_data;

  modport master (
    output cmd_valid, cmd_base_a, cmd_base_b, cmd_len, cmd_seed, res_ready,
    input  cmd_ready, res_valid, res_data
  );
  modport slave (
    input  cmd_valid, cmd_base_a, cmd_base_b, cmd_len, cmd_seed, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/operand_addr_gen.sv
// Latches operand bases and length, walks idx, and produces wrapped read addresses.
module operand_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] cmd_base_a,
  input  logic [ADDR_W-1:0] cmd_base_b,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              last,
  output logic              zero_len
);
  logic [ADDR_W-1:0] base_a, base_b;
  logic [LEN_W-1:0]  len_q, idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_a <= '0;
      base_b <= '0;
      len_q  <= '0;
      idx    <= '0;
    end else if (load) begin
      base_a <= cmd_base_a;
      base_b <= cmd_base_b;
      len_q  <= cmd_len;
      idx    <= '0;
    end else if (step) begin
      idx <= idx + LEN_W'(1);
    end
  end

  // Native-width adders give the modulo-2^ADDR_W wrap for free.
  assign addr_a   = base_a + ADDR_W'(idx);
  assign addr_b   = base_b + ADDR_W'(idx);
  assign last     = (idx == len_q - LEN_W'(1));
  assign zero_len = (len_q == '0);
endmodule

// File: rtl/dot_product_sequencer.sv
// Drives one fuseMultAdd lane through seed + sum(A[i]*B[i]) from a dual-read operand RAM.
module dot_product_sequencer
  import matrix_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  dot_product_sequencer_if.slave sched,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr_a,
  output logic [ADDR_W-1:0] mem_addr_b,
  input  logic [WIDTH-1:0]  mem_data_a,
  input  logic [WIDTH-1:0]  mem_data_b,
  output logic [WIDTH-1:0]  fma_a,
  output logic [WIDTH-1:0]  fma_b,
  output logic [WIDTH-1:0]  fma_seed,
  output logic              fma_update,
  output logic              fma_en,
  input  logic [WIDTH-1:0]  fma_acc,
  output logic              busy
);
  seq_state_t state, state_nx;
  logic accept, last, zero_len, pend, first, zero_op;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [WIDTH-1:0]  seed_q;

  assign sched.cmd_ready = rst_n && (state == IDLE);
  assign accept          = sched.cmd_valid && sched.cmd_ready;

  operand_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr (
    .clk(clk), .rst_n(rst_n), .load(accept), .step(mem_rd_en),
    .cmd_base_a(sched.cmd_base_a), .cmd_base_b(sched.cmd_base_b), .cmd_len(sched.cmd_len),
    .addr_a(addr_a), .addr_b(addr_b), .last(last), .zero_len(zero_len)
  );

  // An empty vector still fires one zero-operand update so the seed lands in the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pend    <= 1'b0;
      first   <= 1'b0;
      zero_op <= 1'b0;
      seed_q  <= '0;
    end else begin
      state <= state_nx;
      pend  <= mem_rd_en || (accept && (sched.cmd_len == '0));
      if (accept) begin
        first   <= 1'b1;
        zero_op <= (sched.cmd_len == '0);
        seed_q  <= sched.cmd_seed;
      end else if (pend) begin
        first <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (zero_len) state_nx = DONE;
               else if (last) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    if (sched.res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign mem_rd_en       = (state == RUN) && !zero_len;
  assign mem_addr_a      = mem_rd_en ? addr_a : '0;
  assign mem_addr_b      = mem_rd_en ? addr_b : '0;
  assign fma_en          = pend;
  assign fma_update      = pend && first;
  assign fma_a           = (pend && !zero_op) ? mem_data_a : '0;
  assign fma_b           = (pend && !zero_op) ? mem_data_b : '0;
  assign fma_seed        = seed_q;
  assign sched.res_valid = (state == DONE);
  assign sched.res_data  = (state == DONE) ? fma_acc : '0;
  assign busy            = (state != IDLE);
endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: behavioural RAM and FMA lane, arithmetic reference model.
module tb_dot_product_sequencer;
  logic clk, rst_n;
  logic mem_rd_en, fma_update, fma_en, busy;
  logic [7:0]  mem_addr_a, mem_addr_b;
  logic [31:0] mem_data_a, mem_data_b, fma_a, fma_b, fma_seed, fma_acc;
  logic [31:0] mema [256];
  logic [31:0] memb [256];

  dot_product_sequencer_if #(.WIDTH(32), .ADDR_W(8), .LEN_W(8)) sched ();

  dot_product_sequencer #(.WIDTH(32), .ADDR_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sched(sched),
    .mem_rd_en(mem_rd_en), .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
    .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
    .fma_a(fma_a), .fma_b(fma_b), .fma_seed(fma_seed), .fma_update(fma_update),
    .fma_en(fma_en), .fma_acc(fma_acc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) begin
    mem_data_a <= mema[mem_addr_a];
    mem_data_b <= memb[mem_addr_b];
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) fma_acc <= '0;
    else if (fma_en) fma_acc <= (fma_update ? fma_seed : fma_acc) + fma_a * fma_b;

  int checks = 0, failures = 0;
  int rd_n, en_n, en_first, en_last, upd_n, upd_cycle, rv_cycle;
  logic [31:0] en_a, en_b, en_seed, res;
  logic [7:0]  addr_q [$];

  function automatic logic [31:0] ref_dot(input logic [7:0] ba, input logic [7:0] bb,
                                          input int len, input logic [31:0] seed);
    logic [31:0] s;
    logic [7:0] ia, ib;
    s = seed;
    for (int i = 0; i < len; i++) begin
      ia = ba + 8'(i);
      ib = bb + 8'(i);
      s = s + mema[ia] * memb[ib];
    end
    return s;
  endfunction

  // Offers one command at the next negedge (cycle 0) and records activity until res_valid.
  task automatic issue(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] len,
                       input logic [31:0] seed);
    rd_n = 0; en_n = 0; en_first = -1; en_last = -1; upd_n = 0; upd_cycle = -1; rv_cycle = -1;
    en_a = 'x; en_b = 'x; en_seed = 'x; res = 'x;
    addr_q.delete();
    @(negedge clk);
    sched.cmd_valid = 1'b1; sched.cmd_base_a = ba; sched.cmd_base_b = bb;
    sched.cmd_len = len; sched.cmd_seed = seed;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      sched.cmd_valid = 1'b0;
      if (mem_rd_en) begin rd_n++; addr_q.push_back(mem_addr_a); end
      if (fma_en) begin
        if (en_n == 0) begin en_first = c; en_a = fma_a; en_b = fma_b; en_seed = fma_seed; end
        en_n++; en_last = c;
      end
      if (fma_update) begin upd_n++; upd_cycle = c; end
      if (sched.res_valid) begin rv_cycle = c; res = sched.res_data; break; end
    end
    if (rv_cycle < 0) begin
      checks++; failures++;
      $display("FAIL issue_timeout: res_valid never rose (len=%0d)", len);
    end
  endtask

  task automatic accept_result();
    sched.res_ready = 1'b1;
    @(negedge clk);
    sched.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({sched.cmd_ready, busy, mem_rd_en, fma_en, fma_update, sched.res_valid} !== 6'b0 ||
        mem_addr_a !== 8'h0 || mem_addr_b !== 8'h0 || fma_a !== 0 || fma_b !== 0 ||
        fma_seed !== 0 || sched.res_data !== 0) begin
      failures++;
      $display("FAIL reset_hold: rdy=%b busy=%b rd=%b en=%b upd=%b rv=%b, all required 0",
               sched.cmd_ready, busy, mem_rd_en, fma_en, fma_update, sched.res_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (sched.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1 0", sched.cmd_ready, busy);
    end
  endtask

  task automatic test_basic();
    mema[10] = 1; mema[11] = 2; mema[12] = 3;
    memb[20] = 4; memb[21] = 5; memb[22] = 6;
    issue(8'd10, 8'd20, 8'd3, 32'd10);
    checks++;
    if (res !== 32'd42 || rv_cycle != 5) begin
      failures++; $display("FAIL basic_result: data=%0d cycle=%0d, required 42 at 5", res, rv_cycle);
    end
    checks++;
    if (upd_n != 1 || upd_cycle != 2 || en_n != 3 || en_first != 2 || en_last != 4 || rd_n != 3) begin
      failures++;
      $display("FAIL basic_timing: upd=%0d@%0d en=%0d %0d..%0d rd=%0d, required 1@2 3 2..4 3",
               upd_n, upd_cycle, en_n, en_first, en_last, rd_n);
    end
    accept_result();
  endtask

  task automatic test_zero_len();
    issue(8'd33, 8'd44, 8'd0, 32'hDEADBEEF);
    checks++;
    if (res !== 32'hDEADBEEF || rv_cycle != 2) begin
      failures++; $display("FAIL zero_result: data=%h cycle=%0d, required deadbeef at 2", res, rv_cycle);
    end
    checks++;
    if (rd_n != 0 || en_n != 1 || en_first != 1 || upd_n != 1 || upd_cycle != 1 ||
        en_a !== 0 || en_b !== 0 || en_seed !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL zero_drive: rd=%0d en=%0d@%0d upd=%0d a=%h b=%h seed=%h, required 0 1@1 1 0 0 deadbeef",
               rd_n, en_n, en_first, upd_n, en_a, en_b, en_seed);
    end
    accept_result();
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    exp = ref_dot(8'hFE, 8'h40, 4, 32'd5);
    issue(8'hFE, 8'h40, 8'd4, 32'd5);
    checks++;
    if (addr_q.size() != 4 || addr_q[0] !== 8'hFE || addr_q[1] !== 8'hFF ||
        addr_q[2] !== 8'h00 || addr_q[3] !== 8'h01) begin
      failures++; $display("FAIL wrap_addr: got %0d reads, required FE FF 00 01", addr_q.size());
    end
    checks++;
    if (res !== exp) begin failures++; $display("FAIL wrap_result: data=%h, required %h", res, exp); end
    accept_result();
  endtask

  task automatic test_hold();
    logic [31:0] exp;
    exp = ref_dot(8'd90, 8'd120, 2, 32'd77);
    issue(8'd90, 8'd120, 8'd2, 32'd77);
    sched.cmd_valid = 1'b1; sched.cmd_len = 8'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (sched.res_valid !== 1'b1 || sched.res_data !== exp || sched.cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable: rv=%b data=%h rdy=%b, required 1 %h 0",
                 sched.res_valid, sched.res_data, sched.cmd_ready, exp);
      end
    end
    sched.res_ready = 1'b1; sched.cmd_valid = 1'b0;
    @(negedge clk);
    sched.res_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || sched.cmd_ready !== 1'b1) begin
      failures++; $display("FAIL hold_ignore_cmd: busy=%b rdy=%b, required 0 1", busy, sched.cmd_ready);
    end
    exp = ref_dot(8'd3, 8'd4, 1, 32'd1);
    issue(8'd3, 8'd4, 8'd1, 32'd1);
    checks++;
    if (res !== exp || rv_cycle != 3) begin
      failures++; $display("FAIL hold_second: data=%h cycle=%0d, required %h at 3", res, rv_cycle, exp);
    end
    accept_result();
  endtask

  task automatic test_overflow();
    mema[200] = 32'hFFFFFFFF; memb[201] = 32'd2;
    issue(8'd200, 8'd201, 8'd1, 32'd3);
    checks++;
    if (res !== 32'd1) begin failures++; $display("FAIL overflow: data=%h, required 1", res); end
    accept_result();
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    sched.cmd_valid = 1'b1; sched.cmd_base_a = 8'd50; sched.cmd_base_b = 8'd60;
    sched.cmd_len = 8'd10; sched.cmd_seed = 32'd9;
    @(negedge clk); sched.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr_a !== 8'd52) begin
      failures++; $display("FAIL midrun_idx: rd=%b addr=%h, required 1 34", mem_rd_en, mem_addr_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sched.cmd_ready, busy, mem_rd_en, fma_en, fma_update, sched.res_valid} !== 6'b0 ||
        mem_addr_a !== 8'h0 || mem_addr_b !== 8'h0 || fma_a !== 0 || fma_b !== 0 ||
        fma_seed !== 0 || sched.res_data !== 0) begin
      failures++;
      $display("FAIL midrun_reset: rdy=%b busy=%b rd=%b en=%b addr=%h seed=%h, required all 0",
               sched.cmd_ready, busy, mem_rd_en, fma_en, mem_addr_a, fma_seed);
    end
    @(negedge clk); rst_n = 1'b1;
    mema[70] = 32'd7; memb[80] = 32'd6;
    issue(8'd70, 8'd80, 8'd1, 32'd0);
    checks++;
    if (res !== 32'd42) begin failures++; $display("FAIL midrun_next: data=%0d, required 42", res); end
    accept_result();
  endtask

  task automatic test_back_to_back();
    logic [7:0] ba, bb, len;
    logic [31:0] seed, exp;
    for (int n = 0; n < 8; n++) begin
      ba = 8'($urandom); bb = 8'($urandom); len = 8'($urandom_range(0, 20)); seed = $urandom;
      exp = ref_dot(ba, bb, int'(len), seed);
      sched.res_ready = n[0];
      issue(ba, bb, len, seed);
      checks++;
      if (res !== exp || rv_cycle != int'(len) + 2 || rd_n != int'(len)) begin
        failures++;
        $display("FAIL b2b_%0d: data=%h cycle=%0d reads=%0d, required %h at %0d reads=%0d",
                 n, res, rv_cycle, rd_n, exp, int'(len) + 2, len);
      end
      if (n[0]) begin
        @(negedge clk);
        sched.res_ready = 1'b0;
      end else begin
        accept_result();
      end
    end
  endtask

  initial begin
    sched.cmd_valid = 1'b0; sched.cmd_base_a = '0; sched.cmd_base_b = '0;
    sched.cmd_len = '0; sched.cmd_seed = '0; sched.res_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin mema[i] = $urandom; memb[i] = $urandom; end
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_hold();
    test_overflow();
    test_reset_midrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
